// File: rtl/miriscv_decode_buf_ctrl.sv
// Decode-stage buffer: two-entry skid buffer between fetch and execute.
// Captures instr/pc/imm/illegal on push, presents the oldest entry on pop.
module miriscv_decode_buf_ctrl #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [XLEN-1:0]        in_instr_i,
  input  logic [XLEN-1:0]        in_pc_i,
  output logic [XLEN-1:0]        imm_instr_o,
  input  logic [XLEN-1:0]        imm_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        out_instr_o,
  output logic [XLEN-1:0]        out_pc_o,
  output logic [XLEN-1:0]        out_imm_o,
  output logic                   out_illegal_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            ill;
  } entry_t;

  entry_t [1:0]           mem_q;
  entry_t                 wr_entry;
  entry_t                 head;
  logic [1:0]             count_q;
  logic [1:0]             count_d;
  logic                   rd_ptr_q;
  logic                   wr_ptr_q;
  logic                   push;
  logic                   pop;
  logic                   stall;
  logic [STALL_CNT_W-1:0] stall_q;

  // Handshakes depend only on registered occupancy.
  assign in_ready_o  = (count_q != FULL);
  assign out_valid_o = (count_q != EMPTY);

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  assign imm_instr_o = in_instr_i;

  assign wr_entry.instr = in_instr_i;
  assign wr_entry.pc    = in_pc_i;
  assign wr_entry.imm   = imm_i;
  assign wr_entry.ill   = (in_instr_i[1:0] != 2'b11);

  assign head          = mem_q[rd_ptr_q];
  assign out_instr_o   = head.instr;
  assign out_pc_o      = head.pc;
  assign out_imm_o     = head.imm;
  assign out_illegal_o = head.ill;

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      flush_i: begin
        count_d = EMPTY;
      end
      !flush_i && push && !pop: begin
        count_d = count_q + 2'd1;
      end
      !flush_i && pop && !push: begin
        count_d = count_q - 2'd1;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      count_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q    <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= wr_entry;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  // Back-pressure profiling; saturates, cleared only by reset.
  assign stall = out_valid_o && !out_ready_i && !flush_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      stall_q <= '0;
    end else if (stall && !(&stall_q)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_miriscv_decode_buf_ctrl.sv
// Bench for miriscv_decode_buf_ctrl: queue scoreboard plus
// occupancy/stall model checked every falling edge.
module tb_miriscv_decode_buf_ctrl;

  localparam int XLEN = 32;
  localparam int SW   = 8;

  logic            clk_i = 1'b0;
  logic            arstn_i;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] in_instr_i;
  logic [XLEN-1:0] in_pc_i;
  logic [XLEN-1:0] imm_instr_o;
  logic [XLEN-1:0] imm_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_instr_o;
  logic [XLEN-1:0] out_pc_o;
  logic [XLEN-1:0] out_imm_o;
  logic            out_illegal_o;
  logic [SW-1:0]   stall_cnt_o;

  miriscv_decode_buf_ctrl #(
    .XLEN        (XLEN),
    .STALL_CNT_W (SW)
  ) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_instr_i    (in_instr_i),
    .in_pc_i       (in_pc_i),
    .imm_instr_o   (imm_instr_o),
    .imm_i         (imm_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_instr_o   (out_instr_o),
    .out_pc_o      (out_pc_o),
    .out_imm_o     (out_imm_o),
    .out_illegal_o (out_illegal_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [SW-1:0] exp_stall;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] immgen(input logic [31:0] i);
    logic [31:0] r;
    case (i[6:0])
      7'h13, 7'h03, 7'h67:
        r = {{20{i[31]}}, i[31:20]};
      7'h23:
        r = {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63:
        r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17:
        r = {i[31:12], 12'b0};
      7'h6f:
        r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        r = 32'h0;
    endcase
    return r;
  endfunction

  // Bench acts as the immediate generator, fed from its own stimulus.
  assign imm_i = immgen(in_instr_i);

  always @(negedge clk_i) begin
    int   sz;
    exp_t e;
    if (!arstn_i) begin
      chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
      chk("rst_ready", {31'b0, in_ready_o}, 32'd1);
      chk("rst_instr", out_instr_o, 32'd0);
      chk("rst_ill", {31'b0, out_illegal_o}, 32'd0);
      chk("rst_stall", {24'b0, stall_cnt_o}, 32'd0);
      q.delete();
      exp_stall = '0;
    end else begin
      sz = q.size();
      chk("valid", {31'b0, out_valid_o}, {31'b0, sz != 0});
      chk("ready", {31'b0, in_ready_o}, {31'b0, sz < 2});
      chk("stall", {24'b0, stall_cnt_o}, {24'b0, exp_stall});
      chk("imm_instr", imm_instr_o, in_instr_i);
      if (sz != 0 && !out_ready_i && !flush_i && exp_stall != '1)
        exp_stall = exp_stall + 1'b1;
      if (flush_i) begin
        q.delete();
      end else begin
        if (sz != 0 && out_ready_i) begin
          e = q.pop_front();
          chk("out_instr", out_instr_o, e.instr);
          chk("out_pc", out_pc_o, e.pc);
          chk("out_imm", out_imm_o, e.imm);
          chk("out_ill", {31'b0, out_illegal_o}, {31'b0, e.ill});
          if (e.instr == 32'hFFF00093)
            chk("addi_imm", out_imm_o, 32'hFFFFFFFF);
          if (e.instr == 32'h12345037)
            chk("lui_imm", out_imm_o, 32'h12345000);
          if (e.instr == 32'h00000000) begin
            chk("zero_ill", {31'b0, out_illegal_o}, 32'd1);
            chk("zero_imm", out_imm_o, 32'd0);
          end
        end
        if (in_valid_i && sz < 2) begin
          e.instr = in_instr_i;
          e.pc    = in_pc_i;
          e.imm   = immgen(in_instr_i);
          e.ill   = (in_instr_i[1:0] != 2'b11);
          q.push_back(e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] p);
    logic hs;
    logic done;
    hs   = 1'b0;
    done = 1'b0;
    in_valid_i = 1'b1;
    in_instr_i = ins;
    in_pc_i    = p;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk_i);
      hs = in_ready_o;
      @(posedge clk_i);
      #1;
      done = hs;
    end
    chk("push_accept", {31'b0, done}, 32'd1);
    in_valid_i = 1'b0;
  endtask

  initial begin
    arstn_i     = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_instr_i  = '0;
    in_pc_i     = '0;
    out_ready_i = 1'b0;
    exp_stall   = '0;
    cyc(3);
    arstn_i = 1'b1;

    out_ready_i = 1'b1;
    push(32'hFFF00093, 32'h100);
    cyc(2);

    out_ready_i = 1'b0;
    push(32'h00112223, 32'h104);
    push(32'h00208463, 32'h108);
    in_valid_i = 1'b1;
    in_instr_i = 32'h12345037;
    in_pc_i    = 32'h10c;
    @(negedge clk_i);
    chk("full_noready", {31'b0, in_ready_o}, 32'd0);
    cyc(3);
    chk("stall_nz", {31'b0, stall_cnt_o != 0}, 32'd1);
    out_ready_i = 1'b1;
    push(32'h12345037, 32'h10c);
    cyc(3);

    for (int i = 0; i < 8; i++)
      push(32'h00100093 + (i << 20), 32'h200 + i * 4);
    cyc(2);

    out_ready_i = 1'b0;
    push(32'h00300093, 32'h280);
    push(32'h00400093, 32'h284);
    flush_i     = 1'b1;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00500093;
    out_ready_i = 1'b1;
    cyc(1);
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    chk("flush_valid", {31'b0, out_valid_o}, 32'd0);
    chk("flush_ready", {31'b0, in_ready_o}, 32'd1);
    cyc(1);
    push(32'h00600093, 32'h290);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_instr_i = 32'h00700093;
    cyc(1);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush1_valid", {31'b0, out_valid_o}, 32'd0);
    cyc(1);

    out_ready_i = 1'b1;
    push(32'h00000000, 32'h300);
    cyc(2);

    out_ready_i = 1'b0;
    push(32'h00800093, 32'h400);
    push(32'h00900093, 32'h404);
    @(posedge clk_i);
    #3;
    arstn_i = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("arst_ready", {31'b0, in_ready_o}, 32'd1);
    chk("arst_stall", {24'b0, stall_cnt_o}, 32'd0);
    q.delete();
    cyc(1);
    arstn_i = 1'b1;
    push(32'h00a00093, 32'h500);
    cyc((1 << SW) + 5);
    chk("stall_sat", {24'b0, stall_cnt_o}, {24'b0, {SW{1'b1}}});
    out_ready_i = 1'b1;
    cyc(3);

    chk("drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
